tinyalu_arbiter: RTL and testbench

//   Shares one TinyALU between NUM_REQ requesters. Round-robin grant; drives the ALU's

---
 rtl/tinyalu_pkg.sv | 22 ++
 rtl/tinyalu_rr_picker.sv | 30 +++
 rtl/tinyalu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// TinyALU shared types: op encodings, bus widths and op legality.
package tinyalu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100
  } operation_t;

  function automatic logic is_legal_op(
    input logic [OP_W-1:0] op
  );
    return op <= MUL_OP;
  endfunction

endpackage

// File: rtl/tinyalu_rr_picker.sv
// Round-robin picker: first set request after the pointer, wrapping.
module tinyalu_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU between NUM_REQ requesters.
// Define TINYALU_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES.
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]          rsp_result,
  output logic                      rsp_err,
  output logic                      alu_start,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic                      alu_done,
  input  logic [RES_W-1:0]          alu_result,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("tinyalu_arbiter: unsupported parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_REJECT
  } state_t;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        g_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   g_oh;
  logic [OP_W-1:0]      sel_op;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic                 tmo_hit;

  tinyalu_rr_picker #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (g_idx)
  );

  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign busy      = (state != S_IDLE);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  |= req_a[i*DATA_W +: DATA_W];
        sel_b  |= req_b[i*DATA_W +: DATA_W];
        sel_op |= req_op[i*OP_W +: OP_W];
      end
    end
  end

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;

  // Zero outside WAIT, so every entry to WAIT starts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= IW'(NUM_REQ - 1);
      g_oh       <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req_valid) begin
            ptr  <= g_idx;
            g_oh <= grant;
            if (is_legal_op(sel_op)) begin
              alu_start <= 1'b1;
              alu_op    <= sel_op;
              alu_a     <= sel_a;
              alu_b     <= sel_b;
              state     <= S_ISSUE;
            end else begin
              state <= S_REJECT;
            end
          end
        end
        S_ISSUE: begin
          // no_op never raises done: one start cycle, then respond.
          if (alu_op == NO_OP) begin
            alu_start <= 1'b0;
            rsp_valid <= g_oh;
            state     <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            alu_start  <= 1'b0;
            rsp_valid  <= g_oh;
            rsp_result <= alu_result;
            state      <= S_RESP;
          end else if (tmo_hit) begin
            alu_start <= 1'b0;
            rsp_valid <= g_oh;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_REJECT: begin
          rsp_valid <= g_oh;
          rsp_err   <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Bench for tinyalu_arbiter: behavioural ALU, round-robin model, random traffic.
module tb_tinyalu_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_err;
  logic           alu_start;
  logic [2:0]     alu_op;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic           alu_done;
  logic [15:0]    alu_result;
  logic           busy;

  int errs   = 0;
  int checks = 0;
  int mptr;
  logic [N-1:0] pend;
  int m_op [N];
  int m_a  [N];
  int m_b  [N];

  tinyalu_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_res(input int op, input int a, input int b);
    case (op)
      1:       return (a + b) & 16'hFFFF;
      2:       return a & b;
      3:       return a ^ b;
      4:       return (a * b) & 16'hFFFF;
      default: return 0;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int op, input int a, input int b);
    logic [31:0] o, x, y;
    o = op;
    x = a;
    y = b;
    m_op[i] = op;
    m_a[i]  = a & 8'hFF;
    m_b[i]  = b & 8'hFF;
    req_op[i*3 +: 3] = o[2:0];
    req_a[i*8 +: 8]  = x[7:0];
    req_b[i*8 +: 8]  = y[7:0];
  endtask

  // dly > 0: done dly cycles after start; dly == 0: never done.
  task automatic serve(input int dly);
    int w, op, last_start, rsp_c, exp_res, exp_err;
    bit legal, noop;
    @(posedge clk); #1;
    req_valid = pend;
    alu_done  = 1'b0;
    w = pick(pend, mptr);
    @(negedge clk);
    chk("ready", req_ready, 32'(1) << w);
    chk("busy_idle", busy, 0);
    op    = m_op[w];
    legal = (op <= 4);
    noop  = (op == 0);
    if (!legal) begin
      last_start = 0;  rsp_c = 2;  exp_err = 1; exp_res = 0;
    end else if (noop) begin
      last_start = 1;  rsp_c = 2;  exp_err = 0; exp_res = 0;
    end else if (dly == 0) begin
      last_start = 17; rsp_c = 18; exp_err = 1; exp_res = 0;
    end else begin
      last_start = 1 + dly; rsp_c = 2 + dly; exp_err = 0;
      exp_res = ref_res(op, m_a[w], m_b[w]);
    end
    mptr    = w;
    pend[w] = 1'b0;
    for (int c = 1; c <= rsp_c; c++) begin
      @(posedge clk); #1;
      req_valid = pend;
      alu_done  = legal && !noop && dly > 0 && c == 1 + dly;
      alu_result = alu_done ? 16'(ref_res(int'(alu_op), int'(alu_a), int'(alu_b)))
                            : 16'($urandom);
      @(negedge clk);
      chk("start", alu_start, 32'(c <= last_start));
      if (alu_start) begin
        chk("alu_op", alu_op, op);
        chk("alu_a", alu_a, m_a[w]);
        chk("alu_b", alu_b, m_b[w]);
      end
      chk("ready_busy", req_ready, 0);
      if (c < rsp_c) begin
        chk("rsp_early", rsp_valid, 0);
        chk("busy", busy, 1);
      end else begin
        chk("rsp_valid", rsp_valid, 32'(1) << w);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", rsp_err, exp_err);
      end
    end
    alu_done = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    alu_done   = 1'b0;
    alu_result = '0;
    pend       = '0;
    mptr       = N - 1;
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", alu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_op", alu_op, 0);
    reset_n = 1'b1;

    // All four mul FF*FF at once: served 0,1,2,3.
    for (int i = 0; i < N; i++) set_req(i, 4, 8'hFF, 8'hFF);
    pend = 4'hF;
    for (int i = 0; i < N; i++) serve(3);

    set_req(0, 1, 8'h12, 8'h34);
    pend = 4'b0001;
    serve(1);

    set_req(2, 0, 8'h55, 8'hAA);
    pend = 4'b0100;
    serve(1);

    set_req(1, 6, 8'h01, 8'h02);
    pend = 4'b0010;
    serve(1);

    repeat (30) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 255));
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        set_req(3, $urandom_range(1, 4), $urandom_range(0, 255),
                $urandom_range(0, 255));
        pend[3] = 1'b1;
      end
      serve($urandom_range(1, 4));
    end
    while (pend != '0) serve(2);

    // Reset while waiting on a mul.
    set_req(0, 4, 8'hC3, 8'h5A);
    pend = 4'b0001;
    @(posedge clk); #1;
    req_valid = pend;
    @(negedge clk);
    chk("wr_ready", req_ready, 1);
    pend = '0;
    repeat (3) begin
      @(posedge clk); #1;
      req_valid = '0;
    end
    @(negedge clk);
    chk("wr_start", alu_start, 1);
    chk("wr_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_start", alu_start, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rsp", rsp_valid, 0);
    chk("ar_op", alu_op, 0);
    chk("ar_a", alu_a, 0);
    chk("ar_err", rsp_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_no_rsp", rsp_valid, 0);
    mptr = N - 1;
    set_req(0, 1, 8'h12, 8'h34);
    pend = 4'b0001;
    serve(2);

`ifdef TINYALU_ARB_TIMEOUT_EN
    set_req(3, 1, 8'h01, 8'h02);
    pend = 4'b1000;
    serve(0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
